// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit: in-order instruction fetch feeding decode through an FQ_DEPTH-entry queue,
// with redirect flush and late-response discard. Define FETCH_PERF_CNT_EN for perf counters.
module fetch_unit #(
    parameter int unsigned        BIN_DIG  = 32,
    parameter int unsigned        FQ_DEPTH = 4,
    parameter logic [BIN_DIG-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               RST,
    output logic               imem_req_valid,
    output logic [BIN_DIG-1:0] imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [BIN_DIG-1:0] imem_rsp_data,
    output logic               dec_valid,
    output logic [BIN_DIG-1:0] dec_pc,
    output logic [BIN_DIG-1:0] dec_inst,
    input  logic               dec_ready,
    input  logic               redirect_valid,
    input  logic [BIN_DIG-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);

    localparam int unsigned        PW         = $clog2(FQ_DEPTH);
    localparam int unsigned        CW         = $clog2(FQ_DEPTH + 1);
    localparam int unsigned        SW         = CW + 1;
    localparam logic [BIN_DIG-1:0] ALIGN_MASK = ~BIN_DIG'(3);
    localparam logic [BIN_DIG-1:0] PC_STEP    = BIN_DIG'(4);

    logic [BIN_DIG-1:0] r_fetch_pc;
    logic [BIN_DIG-1:0] r_rsp_pc;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      r_outstanding;
    logic [CW-1:0]      r_discard_cnt;
    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [BIN_DIG-1:0] r_q_pc   [FQ_DEPTH];
    logic [BIN_DIG-1:0] r_q_inst [FQ_DEPTH];

    logic [SW-1:0]      w_inflight;
    logic [CW-1:0]      w_out_next;
    logic [BIN_DIG-1:0] w_redirect_pc;
    logic               w_accept;
    logic               w_discard;
    logic               w_push;
    logic               w_pop;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_inflight     = SW'(r_count) + SW'(r_outstanding);
        w_redirect_pc  = redirect_pc & ALIGN_MASK;
        imem_req_valid = 1'b0;
        dec_valid      = 1'b0;
        dec_pc         = '0;
        dec_inst       = '0;
        // RST gates the request directly: silent in reset, first request right after release.
        if (RST && !redirect_valid && (w_inflight < SW'(FQ_DEPTH))) begin
            imem_req_valid = 1'b1;
        end
        if (r_count != '0) begin
            dec_valid = 1'b1;
            dec_pc    = r_q_pc[r_head];
            dec_inst  = r_q_inst[r_head];
        end
    end

    assign imem_req_addr = r_fetch_pc;
    assign w_accept      = imem_req_valid && imem_req_ready;
    assign w_pop         = dec_valid && dec_ready;
    assign w_discard     = imem_rsp_valid && (r_discard_cnt != '0);
    assign w_push        = imem_rsp_valid && !w_discard && !redirect_valid;
    assign w_out_next    = r_outstanding + CW'(w_accept) - CW'(imem_rsp_valid);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_fetch_pc    <= RESET_PC & ALIGN_MASK;
            r_rsp_pc      <= RESET_PC & ALIGN_MASK;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard_cnt <= '0;
            r_head        <= '0;
            r_tail        <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect_valid) begin
                // Everything still in flight, minus a response landing now, is stale.
                r_fetch_pc    <= w_redirect_pc;
                r_rsp_pc      <= w_redirect_pc;
                r_count       <= '0;
                r_head        <= '0;
                r_tail        <= '0;
                r_discard_cnt <= w_out_next;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                end
                if (w_discard) begin
                    r_discard_cnt <= r_discard_cnt - CW'(1);
                end
                if (w_push) begin
                    r_tail   <= r_tail + PW'(1);
                    r_rsp_pc <= r_rsp_pc + PC_STEP;
                end
                if (w_pop) begin
                    r_head <= r_head + PW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // NOTE: queue storage has no reset; r_count alone decides which entries are meaningful.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_q_pc[r_tail]   <= r_rsp_pc;
            r_q_inst[r_tail] <= imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_pop && (r_perf_fetched != '1)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (dec_ready && !dec_valid && !redirect_valid && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// tb_fetch_unit: directed stimulus with a scoreboard of expected decode entries; a monitor
// pops and compares on every decode handshake, and a memory model answers fetch requests.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
    logic        dec_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    exp_t        sb[$];
    mreq_t       mq[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    bit          b2b_en = 1'b0;
    bit          have_last = 1'b0;
    int          last_cyc = 0;
    logic [31:0] exp_fetch = 32'h0;
    logic        m_acc;
    logic [31:0] m_addr;

    fetch_unit #(
        .BIN_DIG (32),
        .FQ_DEPTH(4),
        .RESET_PC(32'h0000_0100)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .dec_valid     (dec_valid),
        .dec_pc        (dec_pc),
        .dec_inst      (dec_inst),
        .dec_ready     (dec_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], 16'h0013} ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Memory: in-order responses, mem_lat cycles after acceptance, data derived from the address.
    initial begin
        mreq_t h;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge CLK);
            m_acc  = RST && imem_req_valid && imem_req_ready;
            m_addr = imem_req_addr;
            @(posedge CLK);
            #1;
            if (!RST) begin
                mq.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end else begin
                if (m_acc) mq.push_back('{m_addr, cyc + mem_lat - 1});
                if (mq.size() != 0 && mq[0].due <= cyc) begin
                    h = mq.pop_front();
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = inst_of(h.addr);
                end else begin
                    imem_rsp_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: every decode handshake must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST && dec_valid && dec_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL dec_unexpected: got pc 0x%08h, expected no entry (t=%0t)", dec_pc, $time);
                end else begin
                    e = sb.pop_front();
                    check("dec_pc", dec_pc, e.pc);
                    check("dec_inst", dec_inst, e.inst);
                end
                if (b2b_en && have_last) check("dec_back2back", 32'(cyc), 32'(last_cyc + 1));
                last_cyc  = cyc;
                have_last = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Offers requests from a post-edge point; each accept is address-checked and optionally queued.
    task automatic drive_fetch(input int n, input int max_cyc, input bit keep, output int got);
        int c;
        got = 0;
        c   = 0;
        imem_req_ready = 1'b1;
        while (got < n && c < max_cyc) begin
            @(negedge CLK);
            c++;
            if (imem_req_valid) begin
                check("req_addr", imem_req_addr, exp_fetch);
                if (keep) sb.push_back('{exp_fetch, inst_of(exp_fetch)});
                exp_fetch = exp_fetch + 32'd4;
                got++;
            end
        end
        tick();
        imem_req_ready = 1'b0;
    endtask

    task automatic fetch_n(input int n, input bit keep);
        int got;
        drive_fetch(n, 100, keep, got);
        check("fetch_count", 32'(got), 32'(n));
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 100) begin
            @(negedge CLK);
            c++;
        end
        check("drain_left", 32'(sb.size()), 32'h0);
        tick();
        tick();
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(negedge CLK);
        check("rd_req_valid_during", 32'(imem_req_valid), 32'h0);
        tick();
        redirect_valid = 1'b0;
        exp_fetch      = pc & ~32'h3;
        @(negedge CLK);
        check("rd_dec_flushed", 32'(dec_valid), 32'h0);
        check("rd_req_valid_next", 32'(imem_req_valid), 32'h1);
        check("rd_req_addr_next", imem_req_addr, exp_fetch);
        tick();
    endtask

    initial begin
        int got;
        RST            = 1'b0;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state, with ready high so a leaking request would be visible.
        repeat (3) @(negedge CLK);
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_dec_valid", 32'(dec_valid), 32'h0);
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_dec_inst", dec_inst, 32'h0);
        imem_req_ready = 1'b0;
        tick();
        RST       = 1'b1;
        exp_fetch = 32'h100;
        @(negedge CLK);
        check("first_req_valid", 32'(imem_req_valid), 32'h1);
        check("first_req_addr", imem_req_addr, 32'h100);
        tick();

        // Streaming: one decode entry per cycle from 0x100.
        dec_ready = 1'b1;
        have_last = 1'b0;
        b2b_en    = 1'b1;
        fetch_n(6, 1'b1);
        wait_drain();
        b2b_en = 1'b0;

        // Async reset mid-stream with a partly filled queue.
        dec_ready = 1'b0;
        fetch_n(3, 1'b0);
        tick();
        tick();
        @(negedge CLK);
        check("pre_rst_dec_valid", 32'(dec_valid), 32'h1);
        check("pre_rst_req_valid", 32'(imem_req_valid), 32'h1);
        #2 RST = 1'b0;
        #1;
        check("async_rst_dec_valid", 32'(dec_valid), 32'h0);
        check("async_rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("async_rst_dec_pc", dec_pc, 32'h0);
        imem_req_ready = 1'b1;
        tick();
        tick();
        @(negedge CLK);
        check("rst_hold_req_valid", 32'(imem_req_valid), 32'h0);
        tick();
        imem_req_ready = 1'b0;
        RST            = 1'b1;
        exp_fetch      = 32'h100;
        dec_ready      = 1'b1;
        @(negedge CLK);
        check("rerst_req_valid", 32'(imem_req_valid), 32'h1);
        check("rerst_req_addr", imem_req_addr, 32'h100);
        tick();

        // Stalled request: address held at 0x108, then sequence continues.
        fetch_n(2, 1'b1);
        repeat (5) begin
            @(negedge CLK);
            check("stall_req_valid", 32'(imem_req_valid), 32'h1);
            check("stall_req_addr", imem_req_addr, 32'h108);
        end
        tick();
        fetch_n(2, 1'b1);
        wait_drain();

        // Backpressure: decode stalled 10 cycles -> exactly FQ_DEPTH accepts.
        dec_ready = 1'b0;
        drive_fetch(100, 10, 1'b1, got);
        check("bp_accepts", 32'(got), 32'h4);
        @(negedge CLK);
        check("bp_req_valid", 32'(imem_req_valid), 32'h0);
        check("bp_dec_valid", 32'(dec_valid), 32'h1);
        tick();
        dec_ready = 1'b1;
        wait_drain();

        // Redirect with 2 queued and 2 outstanding responses, all stale.
        dec_ready = 1'b0;
        mem_lat   = 1;
        fetch_n(2, 1'b0);
        mem_lat = 3;
        fetch_n(2, 1'b0);
        @(negedge CLK);
        check("rd_dec_valid_pre", 32'(dec_valid), 32'h1);
        tick();
        redirect(32'h203);
        dec_ready = 1'b1;
        fetch_n(2, 1'b1);
        wait_drain();

        // Wrap-around of fetch_pc.
        mem_lat = 1;
        redirect(32'hFFFF_FFFC);
        fetch_n(2, 1'b1);
        wait_drain();

        check("sb_empty_end", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter BIN_DIG, default 32 (from defs), giving the data/address width.
REQ-002 SHALL have parameter FQ_DEPTH, default 4, giving the fetch queue entries; legal values are a power of 2, 2..16.
REQ-003 SHALL have parameter RESET_PC, default 0, giving the PC after reset.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on posedge.
REQ-005 SHALL have port RST, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have ports imem_req_valid (output, 1) and imem_req_addr (output, BIN_DIG): instruction fetch request.
REQ-007 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-008 SHALL have ports imem_rsp_valid (input, 1) and imem_rsp_data (input, BIN_DIG): in-order response, at least 1 cycle after acceptance.
REQ-009 SHALL have ports dec_valid (output, 1), dec_pc (output, BIN_DIG) and dec_inst (output, BIN_DIG): to decode, next_pc_reg/next_inst source.
REQ-010 SHALL have port dec_ready, input, 1 bit: decode consumes the head entry.
REQ-011 SHALL have ports redirect_valid (input, 1) and redirect_pc (input, BIN_DIG): branch/jump redirect from exec.

Function
REQ-012 SHALL transfer a request when imem_req_valid and imem_req_ready are both 1 in the same cycle; fetch_pc then advances by 4 (wraps modulo 2^BIN_DIG).
REQ-013 SHALL drive imem_req_addr equal to fetch_pc, with bits [1:0] always 0.
REQ-014 SHALL assert imem_req_valid only when (queued + outstanding) < FQ_DEPTH and redirect_valid = 0, which guarantees every response a free slot.
REQ-015 SHALL hold imem_req_addr stable while imem_req_valid = 1 and imem_req_ready = 0, unless a redirect occurs.
REQ-016 SHALL write each kept response {pc, data} into the queue tail; the entry becomes visible on dec_* the next cycle (minimum fetch-to-decode latency: accept -> rsp -> +1 cycle).
REQ-017 SHALL drive dec_valid = 1 exactly when the queue is non-empty; dec_pc/dec_inst show the head entry and stay stable until dec_valid and dec_ready are both 1.
REQ-018 SHALL perform push and pop in the same cycle on a full or empty queue without loss or duplication; occupancy is unchanged.
REQ-019 SHALL, when redirect_valid = 1, on that edge: flush the queue (dec_valid = 0 next cycle), set fetch_pc to {redirect_pc[BIN_DIG-1:2], 2'b00}, and set discard_cnt to the outstanding count (including any request accepted that same cycle).
REQ-020 SHALL drop responses while discard_cnt > 0, decrementing discard_cnt by 1 per response; a response arriving in the redirect cycle itself also counts as discarded.
REQ-021 SHALL treat redirect as highest priority: in its cycle no push is made, and a dec pop in that cycle is still counted as consumed.
REQ-022 SHALL resume requests in the cycle after a redirect, without waiting for discards to drain.
REQ-023 SHALL size the outstanding counter and discard_cnt to hold FQ_DEPTH with no overflow.

Reset
REQ-024 SHALL, while RST = 0 (immediately, asynchronously), set: fetch_pc = RESET_PC, queue empty, outstanding = 0, discard_cnt = 0, imem_req_valid = 0, dec_valid = 0, dec_pc = 0, dec_inst = 0.
REQ-025 SHALL abandon in-flight requests when reset is asserted mid-operation; the memory side is reset together with this block.
REQ-026 SHALL issue the first request (addr = RESET_PC) in the first cycle after RST deasserts.

Configuration
REQ-027 SHALL implement the performance counters only when macro FETCH_PERF_CNT_EN is defined; this adds outputs perf_fetched and perf_stall (each 32 bits, reset 0, saturating).
REQ-028 SHALL, with FETCH_PERF_CNT_EN defined: increment perf_fetched on each dec handshake, and increment perf_stall on each cycle with dec_ready = 1, dec_valid = 0 and no redirect.
REQ-029 SHALL, without FETCH_PERF_CNT_EN: have no such ports and no counter logic.

Verification
REQ-030 SHALL cover reset/streaming: RESET_PC = 0x100, ready = 1, rsp 1-cycle latency, dec_ready = 1 -> dec_pc = 0x100, 0x104, 0x108 on consecutive cycles, one per cycle.
REQ-031 SHALL cover backpressure: dec_ready = 0 for 10 cycles -> exactly FQ_DEPTH (4) entries queued, imem_req_valid = 0, no further accepts, no data lost on release.
REQ-032 SHALL cover redirect with 2 outstanding: redirect_pc = 0x203 -> next request address = 0x200, the 2 late responses dropped, first dec_pc after redirect = 0x200.
REQ-033 SHALL cover a stalled request: imem_req_ready = 0 for 5 cycles -> addr held at 0x108, then accepted, sequence continues to 0x10C.
REQ-034 SHALL cover async reset: RST = 0 mid-stream between edges -> dec_valid and imem_req_valid = 0 immediately; after release, the first request is at RESET_PC.
REQ-035 SHALL cover wrap-around: fetch_pc = 0xFFFFFFFC -> the following request address is 0x00000000.
